// File: rtl/fast_ctrl_sequencer.sv
// fast_ctrl_sequencer: WTE / QIE-reset / module-reset fast-control generator for NCH channels,
// sourced from an internal BX counter or resynchronised external inputs, with a debounced reset button.
module fast_ctrl_sequencer #(
    parameter int NCH        = 4,
    parameter int ORBIT_LEN  = 3564,
    parameter int CNT_W      = 12,
    parameter int QIE_RST_BX = 0,
    parameter int WTE_BX     = 3500,
    parameter int PULSE_W    = 1,
    parameter int DEB_CYC    = 1024,
    parameter int RESET_LEN  = 16
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             mode_select,
    input  logic             enable,
    input  logic [NCH-1:0]   chan_enable,
    input  logic             ext_wte_in,
    input  logic             ext_qie_reset_in,
    input  logic             reset_switch,
    output logic [NCH-1:0]   wte_out,
    output logic [NCH-1:0]   qie_reset_out,
    output logic             reset_out,
    output logic [CNT_W-1:0] bx_count,
    output logic             orbit_sync
);
    localparam int PC_W = $clog2(PULSE_W + 1);
    localparam int DC_W = $clog2(DEB_CYC + 2);
    localparam int RL_W = $clog2(RESET_LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ORBIT_LEN - 1);
    localparam logic [CNT_W-1:0] Q_BX = CNT_W'(QIE_RST_BX);
    localparam logic [CNT_W-1:0] W_BX = CNT_W'(WTE_BX);
    localparam logic [CNT_W-1:0] PW_B = CNT_W'(PULSE_W);
    localparam logic [PC_W-1:0]  PW_C = PC_W'(PULSE_W);

    logic [1:0]       wte_sy, qie_sy, sw_sy, mode_sy;
    logic             wte_prev, qie_prev, active_mode;
    logic [PC_W-1:0]  wte_cnt, qie_cnt, wte_cnt_next, qie_cnt_next;
    logic [DC_W-1:0]  deb_cnt, deb_next;
    logic [RL_W-1:0]  rst_cnt, rst_cnt_next;
    logic [CNT_W-1:0] bx_next, q_off, w_off;
    logic             wte_ext, qie_ext, wte_rise, qie_rise;
    logic             wrap, mode_next, fire, rst_next, wte_p, qie_p;

    always_comb begin
        wte_ext      = ~wte_sy[1];
        qie_ext      = ~qie_sy[1];
        wte_rise     = wte_ext & ~wte_prev & ~active_mode & (wte_cnt == '0);
        qie_rise     = qie_ext & ~qie_prev & ~active_mode & (qie_cnt == '0);
        wte_cnt_next = wte_rise ? PW_C : (wte_cnt != '0) ? wte_cnt - 1'b1 : '0;
        qie_cnt_next = qie_rise ? PW_C : (qie_cnt != '0) ? qie_cnt - 1'b1 : '0;
        // counter parks at DEB_CYC+1 so a held button fires only once
        fire         = sw_sy[1] && (deb_cnt == DC_W'(DEB_CYC));
        deb_next     = !sw_sy[1] ? '0 : (deb_cnt == DC_W'(DEB_CYC + 1)) ? deb_cnt : deb_cnt + 1'b1;
        rst_cnt_next = fire ? RL_W'(RESET_LEN) : (rst_cnt != '0) ? rst_cnt - 1'b1 : '0;
        rst_next     = rst_cnt_next != '0;
        wrap         = bx_count == LAST;
        // qie_cnt == PULSE_W marks the first cycle of an external QIE reset: realign the orbit
        bx_next      = (rst_next || wrap || qie_cnt == PW_C) ? '0 : bx_count + 1'b1;
        mode_next    = wrap ? mode_sy[1] : active_mode;
        q_off        = bx_next - Q_BX;
        w_off        = bx_next - W_BX;
        qie_p        = (mode_next && q_off < PW_B) || qie_cnt != '0;
        wte_p        = (mode_next && w_off < PW_B) || wte_cnt != '0;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wte_sy        <= '1;
            qie_sy        <= '1;
            sw_sy         <= '0;
            mode_sy       <= '0;
            wte_prev      <= 1'b0;
            qie_prev      <= 1'b0;
            wte_cnt       <= '0;
            qie_cnt       <= '0;
            deb_cnt       <= '0;
            rst_cnt       <= '0;
            active_mode   <= 1'b0;
            bx_count      <= '0;
            orbit_sync    <= 1'b0;
            reset_out     <= 1'b0;
            wte_out       <= '0;
            qie_reset_out <= '0;
        end else begin
            wte_sy        <= {wte_sy[0], ext_wte_in};
            qie_sy        <= {qie_sy[0], ext_qie_reset_in};
            sw_sy         <= {sw_sy[0], reset_switch};
            mode_sy       <= {mode_sy[0], mode_select};
            wte_prev      <= wte_ext;
            qie_prev      <= qie_ext;
            wte_cnt       <= wte_cnt_next;
            qie_cnt       <= qie_cnt_next;
            deb_cnt       <= deb_next;
            rst_cnt       <= rst_cnt_next;
            active_mode   <= mode_next;
            bx_count      <= bx_next;
            orbit_sync    <= (bx_next == '0) && !rst_next;
            reset_out     <= rst_next;
            wte_out       <= (wte_p && enable && !rst_next) ? chan_enable : '0;
            qie_reset_out <= (qie_p && enable && !rst_next) ? chan_enable : '0;
        end
    end
endmodule

// File: tb/tb_fast_ctrl_sequencer.sv
// tb_fast_ctrl_sequencer: directed bench with a cycle-accurate BX phase reference.
module tb_fast_ctrl_sequencer;
    localparam int ORB = 16;
    logic       clk = 1'b0;
    logic       reset_in, mode_select, enable, ext_wte_in, ext_qie_reset_in, reset_switch;
    logic [3:0] chan_enable, wte_out, qie_reset_out, bx_count;
    logic       reset_out, orbit_sync;
    int         checks = 0, failures = 0, ph = 0;
    bit         hold = 1'b0, er = 1'b0;

    fast_ctrl_sequencer #(
        .NCH(4), .ORBIT_LEN(ORB), .CNT_W(4), .QIE_RST_BX(2), .WTE_BX(10),
        .PULSE_W(2), .DEB_CYC(8), .RESET_LEN(4)
    ) dut (
        .clk_in(clk), .reset_in(reset_in), .mode_select(mode_select), .enable(enable),
        .chan_enable(chan_enable), .ext_wte_in(ext_wte_in), .ext_qie_reset_in(ext_qie_reset_in),
        .reset_switch(reset_switch), .wte_out(wte_out), .qie_reset_out(qie_reset_out),
        .reset_out(reset_out), .bx_count(bx_count), .orbit_sync(orbit_sync)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t ph=%0d", tag, got, exp, $time, ph);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        ph = hold ? 0 : (ph + 1) % ORB;
    endtask

    task automatic cmp(input logic [3:0] eq, input logic [3:0] ew);
        chk("qie", 32'(qie_reset_out), 32'(eq));
        chk("wte", 32'(wte_out), 32'(ew));
        chk("bx", 32'(bx_count), 32'(ph));
        chk("osync", 32'(orbit_sync), 32'(ph == 0 && !hold));
        chk("rst_out", 32'(reset_out), 32'(er));
    endtask

    task automatic run(input int n, input bit intl, input logic [3:0] m);
        for (int i = 0; i < n; i++) begin
            adv();
            cmp((intl && (ph == 2 || ph == 3)) ? m : 4'h0, (intl && (ph == 10 || ph == 11)) ? m : 4'h0);
        end
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_qie"}, 32'(qie_reset_out), 0);
        chk({tag, "_wte"}, 32'(wte_out), 0);
        chk({tag, "_bx"}, 32'(bx_count), 0);
        chk({tag, "_osync"}, 32'(orbit_sync), 0);
        chk({tag, "_rst"}, 32'(reset_out), 0);
    endtask

    initial begin
        reset_in = 1'b1; mode_select = 1'b1; enable = 1'b1; chan_enable = 4'hF;
        ext_wte_in = 1'b1; ext_qie_reset_in = 1'b1; reset_switch = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle_checks("reset");
        reset_in = 1'b0;
        // first orbit is external even though mode_select is already high
        run(15, 1'b0, 4'hF);
        run(32, 1'b1, 4'hF);
        chan_enable = 4'h5;
        run(16, 1'b1, 4'h5);
        enable = 1'b0;
        run(16, 1'b1, 4'h0);
        enable = 1'b1; chan_enable = 4'hF;
        run(4, 1'b1, 4'hF);
        mode_select = 1'b0;
        run(13, 1'b1, 4'hF);
        run(6, 1'b0, 4'hF);
        // external QIE reset low for 5 cycles from bx 7: one pulse, orbit realigned
        ext_qie_reset_in = 1'b0;
        run(3, 1'b0, 4'hF);
        ph = ORB - 1;
        adv(); cmp(4'hF, 4'h0);
        adv(); cmp(4'hF, 4'h0);
        ext_qie_reset_in = 1'b1;
        run(5, 1'b0, 4'hF);
        ext_wte_in = 1'b0;
        adv(); cmp(4'h0, 4'h0);
        ext_wte_in = 1'b1;
        run(2, 1'b0, 4'hF);
        adv(); cmp(4'h0, 4'hF);
        adv(); cmp(4'h0, 4'hF);
        run(3, 1'b0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            reset_switch = 1'b1;
            run(5, 1'b0, 4'hF);
            reset_switch = 1'b0;
            run(3, 1'b0, 4'hF);
        end
        reset_switch = 1'b1;
        run(8, 1'b0, 4'hF);
        ext_wte_in = 1'b0;
        run(1, 1'b0, 4'hF);
        ext_wte_in = 1'b1;
        run(1, 1'b0, 4'hF);
        // reset_out window: bx held at 0, the pending external WTE pulse is suppressed
        hold = 1'b1; er = 1'b1;
        run(4, 1'b0, 4'hF);
        hold = 1'b0; er = 1'b0;
        run(20, 1'b0, 4'hF);
        reset_switch = 1'b0;
        mode_select = 1'b1;
        ext_wte_in = 1'b0;
        run(1, 1'b0, 4'hF);
        ext_wte_in = 1'b1;
        run(2, 1'b0, 4'hF);
        adv(); cmp(4'h0, 4'hF);
        reset_in = 1'b1;
        #1;
        idle_checks("async");
        @(posedge clk);
        #1;
        reset_in = 1'b0;
        ph = 0;
        run(15, 1'b0, 4'hF);
        run(16, 1'b1, 4'hF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
